// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle initiator: one bus cycle per valid/ready command,
// response returned on a valid/ready port, with ACK timeout and saturating error count.
module wb_cmd_master #(
    parameter int                   ADDRWIDTH        = 7,
    parameter int                   DATAWIDTH        = 32,
    parameter int                   TIMEOUT_CYCLES   = 16,
    parameter logic [DATAWIDTH-1:0] TIMEOUT_RD_VALUE = 32'hDEAD_DEAD
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,

    input  logic                 CMD_VALID_i,
    output logic                 CMD_READY_o,
    input  logic [ADDRWIDTH-1:0] CMD_ADR_i,
    input  logic                 CMD_WE_i,
    input  logic [3:0]           CMD_BYTE_STB_i,
    input  logic [DATAWIDTH-1:0] CMD_DAT_i,

    output logic                 RSP_VALID_o,
    input  logic                 RSP_READY_i,
    output logic [DATAWIDTH-1:0] RSP_DAT_o,
    output logic                 RSP_TIMEOUT_o,

    output logic [ADDRWIDTH-1:0] WBm_ADR_o,
    output logic                 WBm_CYC_o,
    output logic                 WBm_STB_o,
    output logic                 WBm_WE_o,
    output logic [3:0]           WBm_BYTE_STB_o,
    output logic [DATAWIDTH-1:0] WBm_DAT_o,
    input  logic [DATAWIDTH-1:0] WBm_DAT_i,
    input  logic                 WBm_ACK_i,

    output logic [7:0]           Err_Cnt_o
);

    // state | meaning
    // IDLE  | ready for a command, bus idle
    // BUS   | Wishbone cycle in flight, waiting for ACK or timeout
    // RESP  | response presented, waiting for consumer handshake
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] to_cnt;

    assign CMD_READY_o = (state == IDLE);

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            state          <= IDLE;
            to_cnt         <= '0;
            WBm_CYC_o      <= 1'b0;
            WBm_STB_o      <= 1'b0;
            WBm_ADR_o      <= '0;
            WBm_WE_o       <= 1'b0;
            WBm_BYTE_STB_o <= '0;
            WBm_DAT_o      <= '0;
            RSP_VALID_o    <= 1'b0;
            RSP_DAT_o      <= '0;
            RSP_TIMEOUT_o  <= 1'b0;
            Err_Cnt_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CMD_VALID_i) begin
                        WBm_ADR_o      <= CMD_ADR_i;
                        WBm_WE_o       <= CMD_WE_i;
                        WBm_BYTE_STB_o <= CMD_BYTE_STB_i;
                        WBm_DAT_o      <= CMD_DAT_i;
                        WBm_CYC_o      <= 1'b1;
                        WBm_STB_o      <= 1'b1;
                        to_cnt         <= '0;
                        state          <= BUS;
                    end
                end
                BUS: begin
                    // ACK takes priority over a timeout landing on the same cycle
                    if (WBm_ACK_i) begin
                        WBm_CYC_o     <= 1'b0;
                        WBm_STB_o     <= 1'b0;
                        RSP_VALID_o   <= 1'b1;
                        RSP_DAT_o     <= WBm_WE_o ? '0 : WBm_DAT_i;
                        RSP_TIMEOUT_o <= 1'b0;
                        state         <= RESP;
                    end else if (to_cnt == TO_LAST) begin
                        WBm_CYC_o     <= 1'b0;
                        WBm_STB_o     <= 1'b0;
                        RSP_VALID_o   <= 1'b1;
                        RSP_DAT_o     <= WBm_WE_o ? '0 : TIMEOUT_RD_VALUE;
                        RSP_TIMEOUT_o <= 1'b1;
                        if (Err_Cnt_o != 8'hFF) begin
                            Err_Cnt_o <= Err_Cnt_o + 8'd1;
                        end
                        state         <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (RSP_READY_i) begin
                        RSP_VALID_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized bench for wb_cmd_master: behavioural Wishbone slave with programmable
// ACK latency plus a transaction-level reference model of responses and error count.
module tb_wb_cmd_master;

    localparam int          TO     = 16;
    localparam logic [31:0] TO_VAL = 32'hDEAD_DEAD;
    localparam int          NEVER  = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [6:0]  cmd_adr = '0;
    logic        cmd_we = 1'b0;
    logic [3:0]  cmd_sel = '0;
    logic [31:0] cmd_dat = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_to;
    logic [6:0]  wb_adr;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic        wb_ack = 1'b0;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    wb_cmd_master #(
        .ADDRWIDTH(7), .DATAWIDTH(32), .TIMEOUT_CYCLES(TO), .TIMEOUT_RD_VALUE(TO_VAL)
    ) dut (
        .WBs_CLK_i(clk), .WBs_RST_i(rst),
        .CMD_VALID_i(cmd_valid), .CMD_READY_o(cmd_ready), .CMD_ADR_i(cmd_adr),
        .CMD_WE_i(cmd_we), .CMD_BYTE_STB_i(cmd_sel), .CMD_DAT_i(cmd_dat),
        .RSP_VALID_o(rsp_valid), .RSP_READY_i(rsp_ready), .RSP_DAT_o(rsp_dat),
        .RSP_TIMEOUT_o(rsp_to),
        .WBm_ADR_o(wb_adr), .WBm_CYC_o(wb_cyc), .WBm_STB_o(wb_stb), .WBm_WE_o(wb_we),
        .WBm_BYTE_STB_o(wb_sel), .WBm_DAT_o(wb_dat_o), .WBm_DAT_i(wb_dat_i),
        .WBm_ACK_i(wb_ack), .Err_Cnt_o(err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Slave: ACK rises after slv_lat wait cycles; slv_force injects a stray ACK
    logic [31:0] slv_mem [128];
    logic [31:0] init_mem [128];
    logic        slv_load  = 1'b0;
    logic        slv_force = 1'b0;
    int          slv_lat   = 0;
    int          stb_cnt   = 0;

    assign wb_dat_i = slv_mem[wb_adr];

    always @(posedge clk) begin
        if (slv_load) slv_mem <= init_mem;
        if (slv_force) begin
            wb_ack <= 1'b1;
        end else if (wb_cyc && wb_stb && !wb_ack && stb_cnt == slv_lat) begin
            wb_ack <= 1'b1;
            if (wb_we) slv_mem[wb_adr] <= merge(slv_mem[wb_adr], wb_dat_o, wb_sel);
        end else begin
            wb_ack <= 1'b0;
        end
        stb_cnt <= (wb_cyc && wb_stb && !wb_ack) ? stb_cnt + 1 : 0;
    end

    // Reference model: memory image and error counter at transaction level
    logic [31:0] ref_mem [128];
    int          ref_err = 0;

    task automatic do_cmd(input logic we, input logic [6:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input int lat, input int bp);
        logic        to;
        int          exp_cyc, n;
        logic [31:0] exp_dat;
        logic        bad;
        to      = (lat + 2 > TO);
        exp_cyc = to ? TO : lat + 2;
        if (to) begin
            exp_dat = we ? 32'h0 : TO_VAL;
            if (ref_err < 255) ref_err++;
        end else begin
            exp_dat = we ? 32'h0 : ref_mem[adr];
            if (we) ref_mem[adr] = merge(ref_mem[adr], dat, sel);
        end

        @(negedge clk);
        slv_lat = lat;
        chk("ready_idle", 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat;
        @(negedge clk);
        n   = 0;
        bad = 1'b0;
        while (wb_cyc === 1'b1 && n < 300) begin
            n++;
            if (wb_adr !== adr || wb_we !== we || wb_sel !== sel || wb_dat_o !== dat ||
                wb_stb !== 1'b1 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
            // a command presented during the bus cycle must be ignored
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_adr   = 7'($urandom);
            cmd_dat   = $urandom;
            @(negedge clk);
        end
        chk("bus_hold", 32'(bad), 32'h0);
        chk("cyc_cycles", 32'(n), 32'(exp_cyc));
        chk("rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rsp_dat", rsp_dat, exp_dat);
        chk("rsp_timeout", 32'(rsp_to), 32'(to));
        chk("err_cnt", 32'(err_cnt), 32'(ref_err));
        chk("stb_low", 32'(wb_stb), 32'h0);

        bad = 1'b0;
        for (int i = 0; i < bp; i++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_dat !== exp_dat || rsp_to !== to ||
                cmd_ready !== 1'b0 || wb_cyc !== 1'b0) bad = 1'b1;
        end
        if (bp > 0) chk("bp_stable", 32'(bad), 32'h0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", 32'(rsp_valid), 32'h0);
        chk("ready_back", 32'(cmd_ready), 32'h1);
        chk("no_new_cyc", 32'(wb_cyc), 32'h0);
    endtask

    initial begin
        logic bad;
        for (int i = 0; i < 128; i++) init_mem[i] = $urandom;
        init_mem[0] = 32'h56A3_7E57;
        init_mem[3] = 32'h0;
        ref_mem = init_mem;

        rst = 1'b1; slv_load = 1'b1;
        repeat (3) @(negedge clk);
        slv_load = 1'b0;
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        chk("rst_cyc", 32'(wb_cyc), 32'h0);
        chk("rst_stb", 32'(wb_stb), 32'h0);
        chk("rst_adr", 32'(wb_adr), 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_err", 32'(err_cnt), 32'h0);
        rst = 1'b0;

        do_cmd(1'b0, 7'h00, 4'hF, 32'h0, 0, 0);
        do_cmd(1'b1, 7'h03, 4'h1, 32'h0000_00A5, 0, 0);
        chk("slave_wr", slv_mem[3], 32'h0000_00A5);
        do_cmd(1'b0, 7'h03, 4'hF, 32'h0, 1, 0);
        do_cmd(1'b0, 7'h10, 4'hF, 32'h0, NEVER, 0);
        do_cmd(1'b0, 7'h05, 4'hF, 32'h0, 2, 5);
        do_cmd(1'b0, 7'h06, 4'hF, 32'h0, TO - 2, 0);
        do_cmd(1'b1, 7'h07, 4'hC, 32'h1234_5678, TO - 2, 0);
        do_cmd(1'b0, 7'h07, 4'hF, 32'h0, TO - 1, 2);
        do_cmd(1'b1, 7'h08, 4'hF, 32'hCAFE_F00D, TO - 1, 0);

        for (int t = 0; t < 80; t++) begin
            int lat;
            lat = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, TO));
            do_cmd(1'($urandom_range(0, 1)), 7'($urandom), 4'($urandom), $urandom,
                   lat, int'($urandom_range(0, 5)));
        end

        for (int t = 0; t < 300; t++) begin
            do_cmd(1'($urandom_range(0, 1)), 7'($urandom), 4'hF, $urandom, NEVER, 0);
        end
        chk("err_saturated", 32'(err_cnt), 32'd255);

        @(negedge clk);
        slv_lat = NEVER;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 7'h10; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("cyc_before_rst", 32'(wb_cyc), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_err = 0;
        chk("mid_rst_cyc", 32'(wb_cyc), 32'h0);
        chk("mid_rst_stb", 32'(wb_stb), 32'h0);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'h1);
        chk("mid_rst_err", 32'(err_cnt), 32'h0);

        slv_force = 1'b1;
        @(negedge clk);
        slv_force = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0 || cmd_ready !== 1'b1) bad = 1'b1;
        end
        chk("late_ack_ignored", 32'(bad), 32'h0);

        do_cmd(1'b0, 7'h00, 4'hF, 32'h0, 0, 1);
        do_cmd(1'b0, 7'h11, 4'hF, 32'h0, NEVER, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic-cycle initiator for the FPGA fabric. It accepts single read/write commands on a valid/ready command port and runs exactly one Wishbone cycle per command against the fabric register/memory slaves. It returns read data or write completion on a valid/ready response port, and aborts with a timeout indication if the slave never acknowledges. It sits between on-fabric controllers (sequencers, DMA-style engines) and the existing Wishbone register slaves.

## Interface
Parameters:
- ADDRWIDTH, 7, Wishbone address width.
- DATAWIDTH, 32, Wishbone data width.
- TIMEOUT_CYCLES, 16, maximum cycles CYC may stay high without ACK (2..255).
- TIMEOUT_RD_VALUE, 32'hDEAD_DEAD, read data returned on timed-out reads.

Ports:
- WBs_CLK_i  in  1  single clock for the whole block.
- WBs_RST_i  in  1  reset, synchronous, active-high.
- CMD_VALID_i  in  1  command present.
- CMD_READY_o  out  1  block can accept a command.
- CMD_ADR_i  in  ADDRWIDTH  target address.
- CMD_WE_i  in  1  1 = write, 0 = read.
- CMD_BYTE_STB_i  in  4  byte enables.
- CMD_DAT_i  in  DATAWIDTH  write data.
- RSP_VALID_o  out  1  response present.
- RSP_READY_i  in  1  consumer takes the response.
- RSP_DAT_o  out  DATAWIDTH  read data; 0 for writes.
- RSP_TIMEOUT_o  out  1  cycle aborted by timeout.
- WBm_ADR_o  out  ADDRWIDTH  Wishbone address.
- WBm_CYC_o  out  1  cycle.
- WBm_STB_o  out  1  strobe.
- WBm_WE_o  out  1  write enable.
- WBm_BYTE_STB_o  out  4  byte select.
- WBm_DAT_o  out  DATAWIDTH  write data.
- WBm_DAT_i  in  DATAWIDTH  read data from slave.
- WBm_ACK_i  in  1  slave acknowledge.
- Err_Cnt_o  out  8  saturating timeout count.

## Operation
- FSM states: IDLE, BUS, RESP. Reset state is IDLE.
- IDLE:
  - CMD_READY_o=1, all other control outputs 0.
  - On CMD_VALID_i & CMD_READY_o: latch ADR/WE/BYTE_STB/DAT into WBm_* registers, set CYC=STB=1, clear the timeout counter, go to BUS.
- BUS:
  - CYC=STB=1. Address, WE, byte select and data are held constant.
  - WBm_ACK_i=1: drop CYC/STB and raise RSP_VALID_o. RSP_DAT_o = WBm_DAT_i for reads, 0 for writes. RSP_TIMEOUT_o=0. Go to RESP.
  - No ACK and counter == TIMEOUT_CYCLES-1: drop CYC/STB and raise RSP_VALID_o with RSP_TIMEOUT_o=1. RSP_DAT_o = TIMEOUT_RD_VALUE for reads, 0 for writes. Increment Err_Cnt_o, saturating at 255. Go to RESP.
  - Otherwise increment the counter.
- RESP:
  - RSP_VALID_o, RSP_DAT_o and RSP_TIMEOUT_o are held stable until RSP_READY_i=1.
  - On handshake go to IDLE and deassert RSP_VALID_o.
- WBm_ADR/WE/BYTE_STB/DAT_o keep their last values outside BUS. Their reset value is 0.
- WBm_ACK_i is ignored in IDLE and RESP (no state change, no count).
- Err_Cnt_o is cleared only by reset.

## Timing
- All outputs are registered. Reset values: CMD_READY_o=1 from the first post-reset cycle (combinational from state=IDLE); everything else 0.
- Acceptance edge E0: CYC/STB high from E0.
- Zero-wait slave (ACK registered one cycle after STB): ACK is seen before E2. At E2, CYC/STB fall and RSP_VALID_o rises. The slave therefore never sees STB with ACK high for a second cycle, so there is no double acknowledge.
- Minimum command period with RSP_READY_i tied 1 is 4 cycles: IDLE, BUS, BUS, RESP.
- Timeout: CYC is high for exactly TIMEOUT_CYCLES cycles, then falls on the same edge RSP_VALID_o rises.
- ACK in the same cycle the counter reaches TIMEOUT_CYCLES-1: ACK wins. Normal response, no error count.
- Synchronous reset in any state, at the next edge:
  - State goes to IDLE; CYC/STB/RSP_VALID_o go to 0; counter is cleared.
  - An in-flight command is discarded and produces no response.
- CMD_VALID_i while not in IDLE: not accepted. The command must be held until CMD_READY_o=1.

## Test plan
- Read: slave acks one cycle after STB, register 0x00 = 0x56A37E57. Command read ADR=0x00 -> CYC high exactly 2 cycles, RSP_VALID_o 2 cycles after acceptance, RSP_DAT_o=0x56A37E57, RSP_TIMEOUT_o=0.
- Write: ADR=0x03, DAT=0x000000A5, BYTE_STB=4'h1 -> WBm_WE_o=1 with stable ADR/DAT/SEL while CYC=1, slave register reads back 0xA5, RSP_DAT_o=0.
- Timeout: slave never acks, read ADR=0x10, TIMEOUT_CYCLES=16 -> CYC high exactly 16 cycles, RSP_TIMEOUT_o=1, RSP_DAT_o=0xDEADDEAD, Err_Cnt_o=1. Repeat 300 times -> Err_Cnt_o saturates at 255.
- Backpressure: RSP_READY_i=0 for 5 cycles after RSP_VALID_o -> response stable for all 5 cycles, CMD_READY_o=0 throughout, next command accepted only after the handshake.
- Reset mid-cycle: assert WBs_RST_i for 1 cycle in BUS -> CYC/STB=0 next edge, no RSP_VALID_o, CMD_READY_o=1. A late ACK after reset causes no response.
- Race: slave acks in exactly the 16th CYC cycle -> normal response, RSP_TIMEOUT_o=0, Err_Cnt_o unchanged. Spurious ACK in IDLE -> no state change.
